sram_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between the fetch stage and the execute/memory stage.
- Presents one req/addr_ok/data_ok handshake port to each requester and drives a single SRAM port.
- Read data returns one cycle after issue. At most one access is issued per cycle.
- Priority is fixed to data, with a bounded-starvation override for instruction fetch.

---
 rtl/sram_port_arbiter_pkg.sv | 24 ++
 rtl/sram_port_arbiter_starve_ctr.sv | 31 +++
 rtl/sram_port_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the fetch/data SRAM port arbiter.
// Bus widths, response tracker states, grant sources.
package sram_port_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_e;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_starve_ctr.sv
// Saturating count of data wins while fetch waits.
// Raises force_inst once the count reaches MAX_STARVE.
module arb_starve_ctr #(
  parameter int MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic gnt_inst,
  input  logic gnt_data,
  output logic force_inst
);

  localparam logic [3:0] MAX_C = 4'(MAX_STARVE);

  logic [3:0] starve_cnt;

  // count data wins over a waiting fetch, clear once fetch moves
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (gnt_inst || !inst_req) begin
      starve_cnt <= 4'd0;
    end else if (gnt_data && starve_cnt != MAX_C) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_inst = (starve_cnt == MAX_C);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between fetch and data.
// Data wins by default; a starving fetch is forced through.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int MAX_STARVE = 4,
  localparam int STRB_W    = strb_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [STRB_W-1:0] sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  grant_e      grant;
  resp_state_e resp_state;
  resp_state_e resp_next;
  logic        resp_wr;
  logic        force_inst;
  logic        go_inst;
  logic        go_data;

  arb_starve_ctr #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .gnt_inst   (grant == GNT_INST),
    .gnt_data   (grant == GNT_DATA),
    .force_inst (force_inst)
  );

  assign go_inst = !rst && inst_req
                && (!data_req || force_inst);
  assign go_data = !rst && data_req && !go_inst;

  // pick this cycle's winner
  always_comb begin
    grant = GNT_NONE;
    unique case (1'b1)
      go_inst: grant = GNT_INST;
      go_data: grant = GNT_DATA;
      default: grant = GNT_NONE;
    endcase
  end

  // response tracker and write flag of the issued access
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_state <= RESP_NONE;
      resp_wr    <= 1'b0;
    end else begin
      resp_state <= resp_next;
      resp_wr    <= (grant == GNT_DATA) && data_wr;
    end
  end

  // next response slot and issue-side outputs
  always_comb begin
    resp_next    = RESP_NONE;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    sram_en      = 1'b0;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    unique case (grant)
      GNT_INST: begin
        resp_next    = RESP_INST;
        inst_addr_ok = 1'b1;
        sram_en      = 1'b1;
        sram_addr    = inst_addr;
      end
      GNT_DATA: begin
        resp_next    = RESP_DATA;
        data_addr_ok = 1'b1;
        sram_en      = 1'b1;
        sram_addr    = data_addr;
        sram_wdata   = data_wdata;
        sram_we      = data_wr ? data_wstrb : '0;
      end
      default: ;
    endcase
  end

  // response pulse one cycle after issue, killed by reset
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    if (!rst) begin
      unique case (resp_state)
        RESP_INST: begin
          inst_data_ok = 1'b1;
          inst_rdata   = sram_rdata;
        end
        RESP_DATA: begin
          data_data_ok = 1'b1;
          data_rdata   = resp_wr ? '0 : sram_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus
// random traffic against a transaction-level model.
module tb_sram_port_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  sram_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_STARVE (MAXS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  // SRAM behavioural model
  logic [31:0] smem [logic [31:0]];

  always @(posedge clk) begin
    logic [31:0] wa;
    logic [31:0] w;
    wa = {sram_addr[31:2], 2'b00};
    if (sram_en) begin
      w = smem.exists(wa) ? smem[wa] : init_word(wa);
      sram_rdata <= w;
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
      smem[wa] = w;
    end else begin
      sram_rdata <= $urandom;
    end
  end

  // reference model state
  logic [31:0] rmem [logic [31:0]];
  int          m_starve;
  int          m_pend;
  logic        m_pend_wr;
  logic [31:0] m_pend_rd;
  int          eg;

  int  n_chk;
  int  n_err;
  byte gq[$];
  logic [31:0] last_irdata;
  logic        last_dok;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return rmem.exists(wa) ? rmem[wa] : init_word(wa);
  endfunction

  // one clock: check mid-cycle, advance the model on the edge
  task automatic cyc();
    logic [31:0] ea;
    logic [3:0]  ewe;
    logic [31:0] ewd;
    logic [31:0] w;
    @(negedge clk);
    eg = 0;
    if (!rst) begin
      if (inst_req && !data_req) eg = 1;
      else if (data_req && !inst_req) eg = 2;
      else if (inst_req && data_req)
        eg = (m_starve == MAXS) ? 1 : 2;
    end
    ea  = (eg == 1) ? inst_addr : (eg == 2) ? data_addr : 32'd0;
    ewe = (eg == 2 && data_wr) ? data_wstrb : 4'd0;
    ewd = (eg == 2) ? data_wdata : 32'd0;
    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(eg == 1));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(eg == 2));
    chk("sram_en", 64'(sram_en), 64'(eg != 0));
    chk("sram_we", 64'(sram_we), 64'(ewe));
    chk("sram_addr", 64'(sram_addr), 64'(ea));
    chk("sram_wdata", 64'(sram_wdata), 64'(ewd));
    chk("inst_data_ok", 64'(inst_data_ok),
        64'(!rst && m_pend == 1));
    chk("inst_rdata", 64'(inst_rdata),
        64'((!rst && m_pend == 1) ? m_pend_rd : 32'd0));
    chk("data_data_ok", 64'(data_data_ok),
        64'(!rst && m_pend == 2));
    chk("data_rdata", 64'(data_rdata),
        64'((!rst && m_pend == 2 && !m_pend_wr)
            ? m_pend_rd : 32'd0));
    gq.push_back(inst_addr_ok ? "I" : data_addr_ok ? "D" : "-");
    if (inst_data_ok) last_irdata = inst_rdata;
    last_dok = data_addr_ok;
    @(posedge clk);
    if (rst) begin
      m_pend   = 0;
      m_starve = 0;
    end else begin
      if (eg == 1 || !inst_req) m_starve = 0;
      else if (eg == 2 && m_starve < MAXS) m_starve++;
      m_pend    = eg;
      m_pend_wr = (eg == 2) && data_wr;
      m_pend_rd = (eg != 0) ? rd_ref(ea) : 32'd0;
      if (eg == 2 && data_wr) begin
        w = rd_ref(ea);
        for (int b = 0; b < 4; b++)
          if (data_wstrb[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
        rmem[{ea[31:2], 2'b00}] = w;
      end
    end
    #1;
  endtask

  task automatic idle();
    inst_req   = 1'b0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'd0;
    data_wdata = 32'd0;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    if ($urandom_range(0, 3) == 0) a = a | 32'h1C000000;
    return a;
  endfunction

  initial begin
    string exp_ord;
    n_chk    = 0;
    n_err    = 0;
    m_starve = 0;
    m_pend   = 0;
    m_pend_wr = 1'b0;
    m_pend_rd = 32'd0;
    last_irdata = 32'd0;
    last_dok = 1'b0;
    rst = 1'b1;
    idle();
    inst_addr = 32'd0;
    data_addr = 32'd0;
    @(posedge clk);
    #1;

    // reset with both requesting
    inst_req  = 1'b1;
    inst_addr = 32'h10;
    data_req  = 1'b1;
    data_addr = 32'h20;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("first_grant_data", 64'(last_dok), 64'd1);
    data_req = 1'b0;
    cyc();
    idle();
    cyc();

    // back-to-back fetch
    inst_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_addr = 32'h1C000000 + 32'(4 * i);
      cyc();
    end
    idle();
    cyc();
    cyc();

    // conflict
    inst_req  = 1'b1;
    inst_addr = 32'h200;
    data_req  = 1'b1;
    data_addr = 32'h100;
    cyc();
    data_req = 1'b0;
    cyc();
    idle();
    cyc();

    // starvation ordering
    gq.delete();
    inst_req  = 1'b1;
    inst_addr = 32'h300;
    data_req  = 1'b1;
    data_addr = 32'h304;
    repeat (8) cyc();
    exp_ord = "DDDDIDDD";
    for (int i = 0; i < 8; i++)
      chk($sformatf("starve_ord%0d", i), 64'(gq[i]),
          64'(exp_ord[i]));
    idle();
    cyc();

    // byte write then fetch of the same word
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h40;
    data_wstrb = 4'hF;
    data_wdata = 32'd0;
    cyc();
    data_wstrb = 4'b0010;
    data_wdata = 32'hAABBCCDD;
    cyc();
    idle();
    inst_req  = 1'b1;
    inst_addr = 32'h40;
    cyc();
    idle();
    cyc();
    chk("raw_fetch", 64'(last_irdata), 64'h0000CC00);

    // reset while a read is in flight
    data_req  = 1'b1;
    data_addr = 32'h80;
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    data_req  = 1'b1;
    data_addr = 32'h80;
    cyc();
    idle();
    cyc();

    // random traffic, requests held until accepted
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!inst_req) begin
        inst_req  = ($urandom_range(0, 2) != 0);
        inst_addr = rnd_addr();
      end
      if (!data_req) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_wr    = $urandom_range(0, 1) == 1;
        data_wstrb = 4'($urandom);
        data_addr  = rnd_addr();
        data_wdata = $urandom;
      end
      cyc();
      if (eg == 1) inst_req = 1'b0;
      if (eg == 2) data_req = 1'b0;
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
